tge_txfull_event_counter: RTL and testbench
===========================================

Name: tge_txfull_event_counter

Overview:
- Upstream feeder of the gbe1 tx-full software counter register: counts 10GbE TX-buffer almost-full episodes in the user clock domain.
- Drives the 32-bit user_data_in of the simulink-to-PPC register that software reads.
- Glitch filter, software clear, enable gate and saturation flag.
- The downstream register performs the OPB clock-domain crossing; this block is single-clock.

Parameters:
- CNT_WIDTH, 32: counter width; cnt_out width.
- FILTER_LEN, 1: consecutive cycles tx_afull must be high before an episode counts (1 = no filter); legal range 1..255.
- SATURATE, 1: 1 = hold at all-ones at max; 0 = wrap to 0.

Ports:
- user_clk  in  1  user/fabric clock, same domain as the 10GbE core TX interface.
- user_rst  in  1  asynchronous, active-high reset.
- tx_afull  in  1  TX buffer almost-full from 10GbE core, synchronous to user_clk.
- ctr_en  in  1  count enable (software register level).
- ctr_rst  in  1  software clear request; acts on rising edge only.
- cnt_out  out  CNT_WIDTH  episode count; to register user_data_in.
- cnt_sat  out  1  sticky: an increment was attempted at max value.
- full_active  out  1  high while in FULL state.

Behaviour:
- Reset (async assert, sync release): cnt_out=0, cnt_sat=0, full_active=0, FSM=IDLE, filter counter=0, ctr_rst history=0.
- FSM states: IDLE, ARMING, FULL.
  - IDLE: tx_afull=1 and FILTER_LEN=1 -> FULL with qualify; tx_afull=1 and FILTER_LEN>1 -> ARMING, filter counter=1.
  - ARMING: tx_afull=0 -> IDLE, no count. Filter counter reaching FILTER_LEN on this sample -> FULL with qualify. Otherwise increment filter counter.
  - FULL: tx_afull=0 -> IDLE. Otherwise stay; no further counts within the episode.
- Qualify: on the edge making the transition into FULL, if ctr_en=1, cnt_out increments. New value is visible immediately after that edge (1-edge latency from the qualifying sample).
- ctr_en gates only the increment; the FSM always tracks tx_afull. An episode qualifying while ctr_en=0 is never counted later.
- Clear:
  - Fires when ctr_rst is sampled 1 and was 0 on the previous edge. Sets cnt_out=0 and cnt_sat=0.
  - FSM state is preserved, so an ongoing FULL episode is not re-counted.
  - ctr_rst held high = single clear.
- Simultaneous clear and qualify: clear wins; cnt_out=0, episode dropped.
- Max value, SATURATE=1: cnt_out stays all-ones; cnt_sat<=1.
- Max value, SATURATE=0: cnt_out wraps to 0; cnt_sat<=1.
- cnt_sat remains set until clear or reset.
- full_active is registered state decode: high in the cycle after the edge entering FULL, low after the edge leaving it.
- Reset mid-episode: returns to IDLE. If tx_afull is still high after release, the episode is re-detected and counted (after filter). This is accepted.
- All arithmetic is unsigned. Filter counter width = 8 bits.

Decomposition:
- Package tge_txfull_pkg: FSM state enum (IDLE, ARMING, FULL), default CNT_WIDTH, FILTER_CNT_W=8.
- Sub-module tge_rise_detect: one-flop rising-edge detector with async active-high reset. Used for ctr_rst.
- Counter and FSM remain in the top module.

Test Plan:
- Reset, FILTER_LEN=1, ctr_en=1; tx_afull high 5 cycles, low, high 3 cycles -> cnt_out 0->1->2; full_active high for 5 then 3 cycles, each lagging tx_afull by 1 cycle.
- FILTER_LEN=4; pulses of 3 cycles and 4 cycles -> only the 4-cycle pulse counts; cnt_out=1, with the increment on the 4th high sample.
- ctr_en=0 during a full episode, then ctr_en=1 while tx_afull is still high -> cnt_out stays 0; the next episode gives 1.
- cnt_out=7, ctr_rst held high 10 cycles with an episode qualifying on the clear edge -> cnt_out=0 and stays 0; a later episode gives 1.
- CNT_WIDTH=4, SATURATE=1; 17 episodes -> cnt_out=15, cnt_sat=1. SATURATE=0 -> cnt_out=1, cnt_sat=1. A clear then gives 0/0.
- Assert user_rst while in FULL with tx_afull high -> outputs 0 immediately (async). After release with tx_afull still high, cnt_out=1.

Source files
------------

// File: rtl/tge_txfull_pkg.sv
// Shared types and constants for the 10GbE TX-full episode counter.
// Holds the FSM state encoding and default widths.
// No logic, no latency, no flow control.
package tge_txfull_pkg;

    localparam int DEF_CNT_WIDTH = 32;
    localparam int FILTER_CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMING = 2'd1,
        ST_FULL   = 2'd2
    } txfull_state_e;

endpackage

// File: rtl/tge_rise_detect.sv
// One-flop rising-edge detector.
// Latency: rise is combinational from din against the previous sampled value.
// No backpressure; level input, single-cycle pulse-qualified output.
module tge_rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic din_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din;
        end
    end

    assign rise = din & ~din_q;

endmodule

// File: rtl/tge_txfull_event_counter.sv
// Counts filtered TX-buffer almost-full episodes for the software tx-full register.
// Latency: count visible one edge after the sample that qualifies the episode.
// No backpressure; tx_afull is observed every cycle, count saturates or wraps at max.
module tge_txfull_event_counter
    import tge_txfull_pkg::*;
#(
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int FILTER_LEN = 1,
    parameter int SATURATE   = 1
) (
    input  logic                 user_clk,
    input  logic                 user_rst,
    input  logic                 tx_afull,
    input  logic                 ctr_en,
    input  logic                 ctr_rst,
    output logic [CNT_WIDTH-1:0] cnt_out,
    output logic                 cnt_sat,
    output logic                 full_active
);

    localparam logic [FILTER_CNT_W:0] FILT_TGT = (FILTER_CNT_W + 1)'(FILTER_LEN);

    txfull_state_e           state_q;
    txfull_state_e           state_nxt;
    logic [FILTER_CNT_W-1:0] filt_q;
    logic [FILTER_CNT_W-1:0] filt_nxt;
    logic [FILTER_CNT_W:0]   filt_inc;
    logic                    qualify;
    logic                    clr;
    logic [CNT_WIDTH-1:0]    cnt_q;
    logic                    sat_q;

    tge_rise_detect u_clr_rise (
        .clk  (user_clk),
        .rst  (user_rst),
        .din  (ctr_rst),
        .rise (clr)
    );

    // Widened by one bit so the compare against FILTER_LEN cannot overflow.
    assign filt_inc = {1'b0, filt_q} + {{FILTER_CNT_W{1'b0}}, 1'b1};

    always_comb begin
        state_nxt = state_q;
        filt_nxt  = filt_q;
        qualify   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tx_afull) begin
                    if (FILTER_LEN == 1) begin
                        state_nxt = ST_FULL;
                        qualify   = 1'b1;
                    end else begin
                        state_nxt = ST_ARMING;
                        filt_nxt  = {{(FILTER_CNT_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            ST_ARMING: begin
                if (!tx_afull) begin
                    state_nxt = ST_IDLE;
                    filt_nxt  = '0;
                end else if (filt_inc == FILT_TGT) begin
                    state_nxt = ST_FULL;
                    filt_nxt  = '0;
                    qualify   = 1'b1;
                end else begin
                    filt_nxt  = filt_inc[FILTER_CNT_W-1:0];
                end
            end
            ST_FULL: begin
                if (!tx_afull) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                filt_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            state_q <= ST_IDLE;
            filt_q  <= '0;
        end else begin
            state_q <= state_nxt;
            filt_q  <= filt_nxt;
        end
    end

    // Clear takes priority over a coincident qualify; that episode is dropped.
    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else if (clr) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else if (qualify && ctr_en) begin
            if (&cnt_q) begin
                sat_q <= 1'b1;
                if (SATURATE != 0) begin
                    cnt_q <= cnt_q;
                end else begin
                    cnt_q <= '0;
                end
            end else begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign cnt_out     = cnt_q;
    assign cnt_sat     = sat_q;
    assign full_active = (state_q == ST_FULL);

endmodule

// File: tb/tb_tge_txfull_event_counter.sv
// Directed bench: four counter instances covering the unfiltered, filtered,
// saturating and wrapping configurations, driven from one linear sequence.
module tb_tge_txfull_event_counter;

    logic clk;
    logic rst;
    logic [3:0] afull;
    logic [3:0] en;
    logic [3:0] crst;

    logic [31:0] cnt0;
    logic [31:0] cnt1;
    logic [3:0]  cnt2;
    logic [3:0]  cnt3;
    logic        sat0, sat1, sat2, sat3;
    logic        fa0, fa1, fa2, fa3;

    int chk_cnt;
    int pass_cnt;

    tge_txfull_event_counter #(.CNT_WIDTH(32), .FILTER_LEN(1), .SATURATE(1)) u_f1 (
        .user_clk(clk), .user_rst(rst), .tx_afull(afull[0]), .ctr_en(en[0]),
        .ctr_rst(crst[0]), .cnt_out(cnt0), .cnt_sat(sat0), .full_active(fa0));

    tge_txfull_event_counter #(.CNT_WIDTH(32), .FILTER_LEN(4), .SATURATE(1)) u_f4 (
        .user_clk(clk), .user_rst(rst), .tx_afull(afull[1]), .ctr_en(en[1]),
        .ctr_rst(crst[1]), .cnt_out(cnt1), .cnt_sat(sat1), .full_active(fa1));

    tge_txfull_event_counter #(.CNT_WIDTH(4), .FILTER_LEN(1), .SATURATE(1)) u_s1 (
        .user_clk(clk), .user_rst(rst), .tx_afull(afull[2]), .ctr_en(en[2]),
        .ctr_rst(crst[2]), .cnt_out(cnt2), .cnt_sat(sat2), .full_active(fa2));

    tge_txfull_event_counter #(.CNT_WIDTH(4), .FILTER_LEN(1), .SATURATE(0)) u_s0 (
        .user_clk(clk), .user_rst(rst), .tx_afull(afull[3]), .ctr_en(en[3]),
        .ctr_rst(crst[3]), .cnt_out(cnt3), .cnt_sat(sat3), .full_active(fa3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    initial begin
        chk_cnt  = 0;
        pass_cnt = 0;
        rst   = 1'b1;
        afull = 4'b0;
        en    = 4'b1111;
        crst  = 4'b0;

        step();
        step();
        chk("rst_cnt0", cnt0, 0);
        chk("rst_sat0", sat0, 0);
        chk("rst_fa0", fa0, 0);
        chk("rst_cnt2", cnt2, 0);
        chk("rst_sat3", sat3, 0);
        rst = 1'b0;
        step();
        chk("idle_cnt0", cnt0, 0);

        // Unfiltered: 5-cycle then 3-cycle episode
        afull[0] = 1'b1;
        chk("t1_fa_lag", fa0, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t1_fa_hi5", fa0, 1);
            chk("t1_cnt_1", cnt0, 1);
        end
        afull[0] = 1'b0;
        step();
        chk("t1_fa_lo", fa0, 0);
        afull[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t1_fa_hi3", fa0, 1);
            chk("t1_cnt_2", cnt0, 2);
        end
        afull[0] = 1'b0;
        step();
        chk("t1_fa_lo2", fa0, 0);

        // Episode qualifying while disabled is never counted
        en[0] = 1'b0;
        afull[0] = 1'b1;
        step();
        chk("t3_dis_cnt", cnt0, 2);
        chk("t3_dis_fa", fa0, 1);
        en[0] = 1'b1;
        step();
        step();
        chk("t3_late_en", cnt0, 2);
        afull[0] = 1'b0;
        step();
        afull[0] = 1'b1;
        step();
        chk("t3_next_ep", cnt0, 3);
        afull[0] = 1'b0;
        step();

        for (int i = 0; i < 4; i++) begin
            afull[0] = 1'b1;
            step();
            afull[0] = 1'b0;
            step();
        end
        chk("t4_pre7", cnt0, 7);

        // Clear coincident with qualify; ctr_rst held high
        crst[0]  = 1'b1;
        afull[0] = 1'b1;
        step();
        chk("t4_clr_win", cnt0, 0);
        chk("t4_clr_fa", fa0, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t4_hold0", cnt0, 0);
        end
        afull[0] = 1'b0;
        step();
        afull[0] = 1'b1;
        step();
        chk("t4_held_single", cnt0, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t4_hold1", cnt0, 1);
        end
        afull[0] = 1'b0;
        crst[0]  = 1'b0;
        step();
        chk("t4_after", cnt0, 1);
        crst[0] = 1'b1;
        step();
        chk("t4_reclr", cnt0, 0);
        crst[0] = 1'b0;
        step();

        // Filter of 4: a 3-cycle pulse is rejected, a 4-cycle pulse counts
        afull[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_short_cnt", cnt1, 0);
            chk("t2_short_fa", fa1, 0);
        end
        afull[1] = 1'b0;
        step();
        afull[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_arm_cnt", cnt1, 0);
        end
        step();
        chk("t2_4th_cnt", cnt1, 1);
        chk("t2_4th_fa", fa1, 1);
        afull[1] = 1'b0;
        step();
        chk("t2_end_fa", fa1, 0);
        chk("t2_end_cnt", cnt1, 1);

        // 4-bit saturate vs wrap
        for (int i = 0; i < 15; i++) begin
            afull[3:2] = 2'b11;
            step();
            afull[3:2] = 2'b00;
            step();
        end
        chk("t5_s1_15", cnt2, 15);
        chk("t5_s1_sat_lo", sat2, 0);
        chk("t5_s0_15", cnt3, 15);
        for (int i = 0; i < 2; i++) begin
            afull[3:2] = 2'b11;
            step();
            afull[3:2] = 2'b00;
            step();
        end
        chk("t5_s1_cnt", cnt2, 15);
        chk("t5_s1_sat", sat2, 1);
        chk("t5_s0_cnt", cnt3, 1);
        chk("t5_s0_sat", sat3, 1);
        crst[3:2] = 2'b11;
        step();
        chk("t5_s1_clr_cnt", cnt2, 0);
        chk("t5_s1_clr_sat", sat2, 0);
        chk("t5_s0_clr_cnt", cnt3, 0);
        chk("t5_s0_clr_sat", sat3, 0);
        crst[3:2] = 2'b00;
        step();

        // Asynchronous reset mid-episode, re-detected after release
        afull[0] = 1'b1;
        step();
        chk("t6_pre_cnt", cnt0, 1);
        chk("t6_pre_fa", fa0, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_cnt", cnt0, 0);
        chk("t6_async_fa", fa0, 0);
        chk("t6_async_cnt1", cnt1, 0);
        step();
        rst = 1'b0;
        step();
        chk("t6_redetect_cnt", cnt0, 1);
        chk("t6_redetect_fa", fa0, 1);
        afull[0] = 1'b0;
        step();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
